ft2232_fifo_emu: RTL and testbench

//  Device-side emulator of the FT2232H 245-style synchronous FIFO bus: plays the chip, not the FPGA master.

---
 rtl/ft_emu_pkg.sv | 22 ++
 rtl/ft_emu_sync_fifo.sv | 58 +++++
 rtl/ft2232_fifo_emu.sv | 163 ++++++++++++++++
 tb/tb_ft2232_fifo_emu.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_emu_pkg.sv
// Shared types and constants for the FT2232H 245-style synchronous FIFO
// device emulator.
//   state_e   : bus-protocol FSM states
//   LFSR_TAPS : Galois mask for x^16 + x^14 + x^13 + x^11 + 1
//   lfsr_next : one right-shift step of the Galois LFSR
package ft_emu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ARM,
    S_RD,
    S_WR,
    S_ERR
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ft_emu_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes pointers)
//   push_i/data_i : write; ignored while full_o
//   pop_i         : read; ignored while empty_o
//   data_o        : head entry, valid whenever empty_o is low
//   full_o/empty_o: status from the current pointers
module ft_emu_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ft2232_fifo_emu.sv
// Device-side emulator of the FT2232H 245-style synchronous FIFO bus. It
// plays the chip: presents RXF#/TXE#, drives the data bus under OE#, pops on
// RD#, captures the bus on WR#, and flags protocol violations.
//   fifo_clk_i / reset_n_i       : bus clock, async active-low reset
//   fifo_rxf_n_o / fifo_txe_n_o  : registered availability flags
//   fifo_oe_n_i/rd_n_i/wr_n_i    : FPGA strobes (active low)
//   fifo_data_io                 : shared 8-bit bus
//   h2f_* / f2h_*                : host-side push / FWFT pop ports
//   rd_count_o / wr_count_o      : bytes delivered / accepted (wrapping)
//   proto_err_o                  : sticky protocol-violation flag
// Optional feature: define FT_EMU_STALL_EN to insert pseudo-random flag
// stalls from a 16-bit Galois LFSR (stall when lfsr[2:0] == 0).
module ft2232_fifo_emu
  import ft_emu_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             fifo_clk_i,
  input  logic             reset_n_i,
  output logic             fifo_rxf_n_o,
  output logic             fifo_txe_n_o,
  input  logic             fifo_oe_n_i,
  input  logic             fifo_rd_n_i,
  input  logic             fifo_wr_n_i,
  inout  logic [7:0]       fifo_data_io,
  input  logic             h2f_wr_en_i,
  input  logic [7:0]       h2f_data_i,
  output logic             h2f_full_o,
  input  logic             f2h_rd_en_i,
  output logic [7:0]       f2h_data_o,
  output logic             f2h_empty_o,
  output logic [CNT_W-1:0] rd_count_o,
  output logic [CNT_W-1:0] wr_count_o,
  output logic             proto_err_o
);

  state_e           state_q, state_d;
  logic             rxf_n_q, rxf_n_d;
  logic             txe_n_q, txe_n_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  logic [7:0] h2f_head;
  logic       h2f_empty;
  logic       f2h_full;
  logic       h2f_pop;
  logic       f2h_push;
  logic       stall;

  ft_emu_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_h2f (
    .clk_i   (fifo_clk_i),
    .rst_ni  (reset_n_i),
    .push_i  (h2f_wr_en_i),
    .data_i  (h2f_data_i),
    .pop_i   (h2f_pop),
    .data_o  (h2f_head),
    .full_o  (h2f_full_o),
    .empty_o (h2f_empty)
  );

  ft_emu_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_f2h (
    .clk_i   (fifo_clk_i),
    .rst_ni  (reset_n_i),
    .push_i  (f2h_push),
    .data_i  (fifo_data_io),
    .pop_i   (f2h_rd_en_i),
    .data_o  (f2h_data_o),
    .full_o  (f2h_full),
    .empty_o (f2h_empty_o)
  );

`ifdef FT_EMU_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr_q <= LFSR_SEED;
    else            lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[2:0] == 3'b000);
`else
  logic [15:0] lfsr_seed_unused;
  assign lfsr_seed_unused = LFSR_SEED;
  assign stall = 1'b0;
`endif

  // Bus is held off during reset so a queued head never leaks onto the pins.
  assign fifo_data_io = (reset_n_i && !fifo_oe_n_i && fifo_wr_n_i) ? h2f_head : 'z;

  // The RD_ARM->RD edge already samples RD# low, so it pops too; every edge
  // with RD# low after the OE#-only arming edge delivers one byte.
  assign h2f_pop  = ((state_q == S_RD_ARM) || (state_q == S_RD)) &&
                    !fifo_oe_n_i && !fifo_rd_n_i && !rxf_n_q && !h2f_empty;
  // The fullness term covers the one-cycle lag of the registered TXE#.
  assign f2h_push = !fifo_wr_n_i && fifo_oe_n_i && !txe_n_q && !f2h_full;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_oe_n_i && !fifo_rd_n_i)      state_d = S_ERR;
        else if (!fifo_oe_n_i)                 state_d = S_RD_ARM;
        else if (!fifo_wr_n_i)                 state_d = S_WR;
      end
      S_RD_ARM: begin
        if (fifo_oe_n_i)                       state_d = S_IDLE;
        else if (!fifo_rd_n_i)                 state_d = S_RD;
      end
      S_RD: begin
        if (fifo_oe_n_i)                       state_d = S_IDLE;
        else if (fifo_rd_n_i)                  state_d = S_RD_ARM;
      end
      S_WR: begin
        if (!fifo_oe_n_i)                      state_d = S_ERR;
        else if (fifo_wr_n_i)                  state_d = S_IDLE;
      end
      S_ERR: begin
        if (fifo_oe_n_i && fifo_rd_n_i && fifo_wr_n_i) state_d = S_IDLE;
      end
      default:                                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rxf_n_d    = h2f_empty | stall;
    txe_n_d    = f2h_full | stall;
    err_d      = err_q | (state_d == S_ERR) |
                 (!fifo_wr_n_i && !fifo_oe_n_i) |
                 (!fifo_rd_n_i && fifo_oe_n_i);
    rd_count_d = rd_count_q + CNT_W'(h2f_pop);
    wr_count_d = wr_count_q + CNT_W'(f2h_push);
  end

  always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      rxf_n_q    <= 1'b1;
      txe_n_q    <= 1'b1;
      err_q      <= 1'b0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rxf_n_q    <= rxf_n_d;
      txe_n_q    <= txe_n_d;
      err_q      <= err_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign fifo_rxf_n_o = rxf_n_q;
  assign fifo_txe_n_o = txe_n_q;
  assign proto_err_o  = err_q;
  assign rd_count_o   = rd_count_q;
  assign wr_count_o   = wr_count_q;

endmodule

// File: tb/tb_ft2232_fifo_emu.sv
// Self-checking bench for ft2232_fifo_emu (default build, stalls disabled).
// A queue-level model tracks both byte streams, the lagged flags, counters
// and the sticky error; one process compares it with the DUT every cycle,
// and directed literal checks pin the key scenarios.
module tb_ft2232_fifo_emu;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             oe_n, rd_n, wr_n;
  logic             h2f_wr_en, f2h_rd_en;
  logic [7:0]       h2f_data;
  logic             tb_drv;
  logic [7:0]       tb_bus;
  wire  [7:0]       bus;
  logic             rxf_n, txe_n, h2f_full, f2h_empty, proto_err;
  logic [7:0]       f2h_data;
  logic [CNT_W-1:0] rd_count, wr_count;

  assign bus = tb_drv ? tb_bus : 'z;

  ft2232_fifo_emu #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
    .fifo_clk_i   (clk),
    .reset_n_i    (rst_n),
    .fifo_rxf_n_o (rxf_n),
    .fifo_txe_n_o (txe_n),
    .fifo_oe_n_i  (oe_n),
    .fifo_rd_n_i  (rd_n),
    .fifo_wr_n_i  (wr_n),
    .fifo_data_io (bus),
    .h2f_wr_en_i  (h2f_wr_en),
    .h2f_data_i   (h2f_data),
    .h2f_full_o   (h2f_full),
    .f2h_rd_en_i  (f2h_rd_en),
    .f2h_data_o   (f2h_data),
    .f2h_empty_o  (f2h_empty),
    .rd_count_o   (rd_count),
    .wr_count_o   (wr_count),
    .proto_err_o  (proto_err)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]       h2f_buf [1024];
  logic [7:0]       f2h_buf [1024];
  int unsigned      h_wr, h_rd, f_wr, f_rd;
  logic             m_rxf, m_txe, m_err, m_lead, m_hold;
  logic [CNT_W-1:0] m_rdc, m_wrc;
  logic             m_hpush, m_hpop, m_pop, m_push, m_enter, m_viol;

  always_comb begin
    m_hpush = h2f_wr_en && ((h_wr - h_rd) < DEPTH);
    m_hpop  = f2h_rd_en && (f_wr != f_rd);
    m_pop   = m_lead && !m_hold && !oe_n && !rd_n && !m_rxf && (h_wr != h_rd);
    m_push  = !wr_n && oe_n && !m_txe && ((f_wr - f_rd) < DEPTH);
    m_enter = !oe_n && !rd_n && !m_lead && !m_hold;
    m_viol  = m_enter || (!wr_n && !oe_n) || (!rd_n && oe_n);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_wr <= 0; h_rd <= 0; f_wr <= 0; f_rd <= 0;
      m_rxf <= 1'b1; m_txe <= 1'b1; m_err <= 1'b0;
      m_lead <= 1'b0; m_hold <= 1'b0;
      m_rdc <= '0; m_wrc <= '0;
    end else begin
      if (m_hpush) begin
        h2f_buf[h_wr % 1024] <= h2f_data;
        h_wr <= h_wr + 1;
      end
      if (m_pop) begin
        h_rd  <= h_rd + 1;
        m_rdc <= m_rdc + 1'b1;
      end
      if (m_push) begin
        f2h_buf[f_wr % 1024] <= tb_bus;
        f_wr  <= f_wr + 1;
        m_wrc <= m_wrc + 1'b1;
      end
      if (m_hpop) f_rd <= f_rd + 1;
      m_rxf  <= (h_wr == h_rd);
      m_txe  <= ((f_wr - f_rd) == DEPTH);
      m_err  <= m_err || m_viol;
      m_hold <= (m_hold || m_enter) && !(oe_n && rd_n && wr_n);
      m_lead <= !oe_n && !m_hold && !m_enter && (rd_n || m_lead);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("rxf_n", 32'(rxf_n), 32'(m_rxf));
      check("txe_n", 32'(txe_n), 32'(m_txe));
      check("h2f_full", 32'(h2f_full), 32'((h_wr - h_rd) == DEPTH));
      check("f2h_empty", 32'(f2h_empty), 32'(f_wr == f_rd));
      check("rd_count", 32'(rd_count), 32'(m_rdc));
      check("wr_count", 32'(wr_count), 32'(m_wrc));
      check("proto_err", 32'(proto_err), 32'(m_err));
      if (f_wr != f_rd) check("f2h_data", 32'(f2h_data), 32'(f2h_buf[f_rd % 1024]));
      if (!oe_n && wr_n && (h_wr != h_rd)) check("bus", 32'(bus), 32'(h2f_buf[h_rd % 1024]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int unsigned gaps;

  initial begin
    rst_n = 1'b0; oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    h2f_wr_en = 1'b0; h2f_data = '0; f2h_rd_en = 1'b0;
    tb_drv = 1'b0; tb_bus = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("init_txe_n", 32'(txe_n), 0);
    check("init_rxf_n", 32'(rxf_n), 1);

    // Reset in the middle of a read burst with bytes queued.
    for (int i = 0; i < 5; i++) begin
      h2f_wr_en = 1'b1; h2f_data = 8'(8'hC1 + i); tick();
    end
    h2f_wr_en = 1'b0;
    oe_n = 1'b0; tick();
    rd_n = 1'b0; tick(); tick();
    rst_n = 1'b0; tb_drv = 1'b1; tb_bus = 8'h00; #1;
    check("rst_bus_released", 32'(bus), 0);
    check("rst_rxf_n", 32'(rxf_n), 1);
    check("rst_txe_n", 32'(txe_n), 1);
    check("rst_rd_count", 32'(rd_count), 0);
    check("rst_wr_count", 32'(wr_count), 0);
    check("rst_f2h_empty", 32'(f2h_empty), 1);
    check("rst_h2f_full", 32'(h2f_full), 0);
    check("rst_proto_err", 32'(proto_err), 0);
    tb_drv = 1'b0; oe_n = 1'b1; rd_n = 1'b1; tick();
    rst_n = 1'b1; tick(); tick();
    check("rel_txe_n", 32'(txe_n), 0);
    check("rel_rxf_n_flushed", 32'(rxf_n), 1);

    // Read burst 11,22,33.
    h2f_wr_en = 1'b1; h2f_data = 8'h11; tick();
    h2f_data = 8'h22; tick();
    h2f_data = 8'h33; tick();
    h2f_wr_en = 1'b0;
    oe_n = 1'b0; tick();
    check("rd_bus0", 32'(bus), 'h11);
    rd_n = 1'b0; tick();
    check("rd_bus1", 32'(bus), 'h22);
    tick();
    check("rd_bus2", 32'(bus), 'h33);
    tick();
    check("rd_count3", 32'(rd_count), 3);
    oe_n = 1'b1; rd_n = 1'b1; tick();
    check("rd_rxf_n_after", 32'(rxf_n), 1);

    // Write A5,5A then host pops.
    tb_drv = 1'b1; tb_bus = 8'hA5; wr_n = 1'b0; tick();
    tb_bus = 8'h5A; tick();
    wr_n = 1'b1; tb_drv = 1'b0; tick();
    check("wr_count2", 32'(wr_count), 2);
    check("f2h_head_a5", 32'(f2h_data), 'hA5);
    f2h_rd_en = 1'b1; tick();
    check("f2h_head_5a", 32'(f2h_data), 'h5A);
    tick();
    f2h_rd_en = 1'b0;
    check("f2h_drained", 32'(f2h_empty), 1);

    // 17 writes into a 16-deep F2H.
    reset_dut();
    tb_drv = 1'b1; wr_n = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tb_bus = 8'(8'h40 + i); tick();
    end
    check("ovf_txe_n", 32'(txe_n), 1);
    check("ovf_wr_count", 32'(wr_count), 16);
    check("ovf_proto_err", 32'(proto_err), 0);
    wr_n = 1'b1; tb_drv = 1'b0; tick();
    for (int i = 0; i < 16; i++) begin
      check("ovf_drain", 32'(f2h_data), 32'('h40 + i));
      f2h_rd_en = 1'b1; tick();
    end
    f2h_rd_en = 1'b0;
    check("ovf_empty", 32'(f2h_empty), 1);

    // 17 host pushes into a 16-deep H2F.
    for (int i = 0; i < 17; i++) begin
      h2f_wr_en = 1'b1; h2f_data = 8'(i); tick();
    end
    h2f_wr_en = 1'b0;
    check("h2f_full", 32'(h2f_full), 1);

    // Protocol violations.
    reset_dut();
    h2f_wr_en = 1'b1; h2f_data = 8'h5A; tick();
    h2f_wr_en = 1'b0;
    oe_n = 1'b0; rd_n = 1'b0; tick();
    check("err_oe_rd", 32'(proto_err), 1);
    oe_n = 1'b1; rd_n = 1'b1; tick();
    check("err_sticky", 32'(proto_err), 1);
    reset_dut();
    check("err_cleared", 32'(proto_err), 0);
    h2f_wr_en = 1'b1; h2f_data = 8'h5A; tick();
    h2f_wr_en = 1'b0; tick();
    tb_drv = 1'b1; tb_bus = 8'hA5; oe_n = 1'b0; wr_n = 1'b0; #1;
    check("wr_oe_bus_off", 32'(bus), 'hA5);
    tick();
    check("err_wr_oe", 32'(proto_err), 1);
    check("wr_oe_bus_off2", 32'(bus), 'hA5);
    oe_n = 1'b1; wr_n = 1'b1; tb_drv = 1'b0; tick();

    // 256-byte H2F stream with concurrent host pushes: no flag gaps.
    reset_dut();
    gaps = 0;
    for (int i = 0; i < 256; i++) begin
      h2f_wr_en = 1'b1; h2f_data = 8'(i);
      if (i == 4) oe_n = 1'b0;
      if (i == 5) rd_n = 1'b0;
      tick();
      if (i >= 6 && rxf_n) gaps++;
    end
    h2f_wr_en = 1'b0;
    repeat (20) tick();
    oe_n = 1'b1; rd_n = 1'b1; tick();
    check("h2f_stream_gaps", gaps, 0);
    check("h2f_stream_count", 32'(rd_count), 256);

    // 256-byte F2H stream with concurrent host pops: no flag gaps.
    reset_dut();
    gaps = 0;
    tb_drv = 1'b1; wr_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tb_bus = 8'(i);
      if (i >= 2) f2h_rd_en = 1'b1;
      tick();
      if (txe_n) gaps++;
    end
    wr_n = 1'b1; tb_drv = 1'b0;
    repeat (10) tick();
    f2h_rd_en = 1'b0; tick();
    check("f2h_stream_gaps", gaps, 0);
    check("f2h_stream_count", 32'(wr_count), 256);
    check("f2h_stream_empty", 32'(f2h_empty), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
